// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU one-hot bit
// positions, multiplier state encoding and the ID->EXE / EXE->MEM bus layouts.
package cpu_defs;

   localparam int ID_EXE_W  = 167;
   localparam int EXE_MEM_W = 154;

   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 10;
   localparam int ALU_SLT  = 9;
   localparam int ALU_SLTU = 8;
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;
   localparam int ALU_SRL  = 2;
   localparam int ALU_SRA  = 1;
   localparam int ALU_LUI  = 0;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   typedef struct packed {
      logic        multiply;
      logic        mthi;
      logic        mtlo;
      logic [11:0] alu_control;
      logic [31:0] alu_operand1;
      logic [31:0] alu_operand2;
      logic [3:0]  mem_control;
      logic [31:0] store_data;
      logic        mfhi;
      logic        mflo;
      logic        mtc0;
      logic        mfc0;
      logic [7:0]  cp0r_addr;
      logic        syscall;
      logic        eret;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] pc;
   } id_exe_t;

   typedef struct packed {
      logic [3:0]  mem_control;
      logic [31:0] store_data;
      logic [31:0] exe_result;
      logic [31:0] lo_result;
      logic        hi_write;
      logic        lo_write;
      logic        mfhi;
      logic        mflo;
      logic        mtc0;
      logic        mfc0;
      logic [7:0]  cp0r_addr;
      logic        syscall;
      logic        eret;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] pc;
   } exe_mem_t;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/multiply_iter.sv
// Radix-2 iterative signed 32x32 multiplier: magnitudes are multiplied one
// multiplier bit per cycle and the sign is restored on the final iteration.
module multiply_iter
   import cpu_defs::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        cancel,
   input  logic        ack,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic        done,
   output logic [63:0] product,
   output mul_state_e  state_o
);

   localparam int CNT_W = $clog2(MUL_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

   mul_state_e       state_q;
   logic [63:0]      mcand_q;
   logic [63:0]      acc_q;
   logic [63:0]      prod_q;
   logic [63:0]      acc_d;
   logic [31:0]      mplier_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q;
   logic             done_q;
   logic             start_neg;

   assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   // A zero operand never takes the sign fix, so -0 cannot appear.
   assign start_neg = (op1[31] ^ op2[31]) & (|op1) & (|op2);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
      end else if (cancel) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (start) begin
                  state_q  <= MUL_BUSY;
                  mcand_q  <= {32'd0, abs32(op1)};
                  mplier_q <= abs32(op2);
                  neg_q    <= start_neg;
                  acc_q    <= '0;
                  prod_q   <= '0;
                  cnt_q    <= '0;
               end
            end
            MUL_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= MUL_DONE;
                  done_q  <= 1'b1;
                  prod_q  <= neg_q ? (~acc_d + 64'd1) : acc_d;
               end
            end
            MUL_DONE: begin
               if (ack) begin
                  state_q <= MUL_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= MUL_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign done    = done_q;
   assign product = prod_q;
   assign state_o = state_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID->EXE pipeline register, inline single-cycle ALU and an
// iterative multiplier, feeding the MEM stage over the EXE->MEM bus.
module exe_stage
   import cpu_defs::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ID_over,
   input  logic [ID_EXE_W-1:0]  ID_EXE_bus,
   input  logic                 MEM_allow_in,
   input  logic                 cancel,
   output logic                 EXE_allow_in,
   output logic                 EXE_valid,
   output logic                 EXE_over,
   output logic [EXE_MEM_W-1:0] EXE_MEM_bus,
   output logic [4:0]           EXE_wdest,
   output logic [31:0]          EXE_pc
);

   id_exe_t     bus_q;
   logic        valid_q;
   exe_mem_t    mem_bus;
   mul_state_e  mul_state;
   logic        mul_done;
   logic [63:0] product;
   logic        mul_start;

   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  sh;
   logic [31:0] alu_res;
   logic [31:0] add_res;
   logic [31:0] sub_res;
   logic [31:0] slt_res;
   logic [31:0] sltu_res;
   logic [31:0] sll_res;
   logic [31:0] srl_res;
   logic [31:0] sra_res;
   logic [31:0] lui_res;

   assign EXE_over     = valid_q & (~bus_q.multiply | mul_done);
   assign EXE_allow_in = ~valid_q | (EXE_over & MEM_allow_in);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         bus_q   <= '0;
      end else begin
         if (ID_over & EXE_allow_in) begin
            bus_q <= ID_EXE_bus;
         end
         if (cancel) begin
            valid_q <= 1'b0;
         end else if (EXE_allow_in) begin
            valid_q <= ID_over;
         end
      end
   end

   assign mul_start = valid_q & bus_q.multiply & (mul_state == MUL_IDLE);

   multiply_iter #(
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .resetn  (resetn),
      .start   (mul_start),
      .cancel  (cancel),
      .ack     (MEM_allow_in),
      .op1     (bus_q.alu_operand1),
      .op2     (bus_q.alu_operand2),
      .done    (mul_done),
      .product (product),
      .state_o (mul_state)
   );

   assign op1      = bus_q.alu_operand1;
   assign op2      = bus_q.alu_operand2;
   assign sh       = op1[4:0];
   assign add_res  = op1 + op2;
   assign sub_res  = op1 - op2;
   assign slt_res  = {31'd0, $signed(op1) < $signed(op2)};
   assign sltu_res = {31'd0, op1 < op2};
   assign sll_res  = op2 << sh;
   assign srl_res  = op2 >> sh;
   // Kept as its own assignment so the shift stays arithmetic.
   assign sra_res  = $signed(op2) >>> sh;
   assign lui_res  = {op2[15:0], 16'h0000};

   always_comb begin
      alu_res = '0;
      if (bus_q.alu_control[ALU_ADD])  alu_res = alu_res | add_res;
      if (bus_q.alu_control[ALU_SUB])  alu_res = alu_res | sub_res;
      if (bus_q.alu_control[ALU_SLT])  alu_res = alu_res | slt_res;
      if (bus_q.alu_control[ALU_SLTU]) alu_res = alu_res | sltu_res;
      if (bus_q.alu_control[ALU_AND])  alu_res = alu_res | (op1 & op2);
      if (bus_q.alu_control[ALU_NOR])  alu_res = alu_res | ~(op1 | op2);
      if (bus_q.alu_control[ALU_OR])   alu_res = alu_res | (op1 | op2);
      if (bus_q.alu_control[ALU_XOR])  alu_res = alu_res | (op1 ^ op2);
      if (bus_q.alu_control[ALU_SLL])  alu_res = alu_res | sll_res;
      if (bus_q.alu_control[ALU_SRL])  alu_res = alu_res | srl_res;
      if (bus_q.alu_control[ALU_SRA])  alu_res = alu_res | sra_res;
      if (bus_q.alu_control[ALU_LUI])  alu_res = alu_res | lui_res;
   end

   always_comb begin
      mem_bus             = '0;
      mem_bus.mem_control = bus_q.mem_control;
      mem_bus.store_data  = bus_q.store_data;
      if (bus_q.multiply) begin
         mem_bus.exe_result = product[63:32];
      end else if (bus_q.mthi | bus_q.mtlo) begin
         mem_bus.exe_result = bus_q.alu_operand1;
      end else begin
         mem_bus.exe_result = alu_res;
      end
      mem_bus.lo_result   = bus_q.multiply ? product[31:0] : bus_q.alu_operand1;
      mem_bus.hi_write    = bus_q.multiply | bus_q.mthi;
      mem_bus.lo_write    = bus_q.multiply | bus_q.mtlo;
      mem_bus.mfhi        = bus_q.mfhi;
      mem_bus.mflo        = bus_q.mflo;
      mem_bus.mtc0        = bus_q.mtc0;
      mem_bus.mfc0        = bus_q.mfc0;
      mem_bus.cp0r_addr   = bus_q.cp0r_addr;
      mem_bus.syscall     = bus_q.syscall;
      mem_bus.eret        = bus_q.eret;
      mem_bus.rf_wen      = bus_q.rf_wen;
      mem_bus.rf_wdest    = bus_q.rf_wdest;
      mem_bus.pc          = bus_q.pc;
   end

   assign EXE_MEM_bus = mem_bus;
   assign EXE_valid   = valid_q;
   assign EXE_wdest   = valid_q ? bus_q.rf_wdest : 5'd0;
   assign EXE_pc      = bus_q.pc;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: randomized instructions checked against a behavioural
// model of the ALU, the signed product and the bus layout.
module tb_exe_stage;

   localparam int MUL_CYCLES = 32;
   localparam int MUL_LAT    = MUL_CYCLES + 1;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ID_over;
   logic [166:0] ID_EXE_bus;
   logic         MEM_allow_in;
   logic         cancel;
   logic         EXE_allow_in;
   logic         EXE_valid;
   logic         EXE_over;
   logic [153:0] EXE_MEM_bus;
   logic [4:0]   EXE_wdest;
   logic [31:0]  EXE_pc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          op;
      logic        mul;
      logic        mthi;
      logic        mtlo;
      logic [11:0] ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  memc;
      logic [31:0] sd;
      logic [3:0]  flags;
      logic [7:0]  cp0;
      logic [1:0]  se;
      logic        wen;
      logic [4:0]  wd;
      logic [31:0] pc;
   } instr_t;

   exe_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ID_over      (ID_over),
      .ID_EXE_bus   (ID_EXE_bus),
      .MEM_allow_in (MEM_allow_in),
      .cancel       (cancel),
      .EXE_allow_in (EXE_allow_in),
      .EXE_valid    (EXE_valid),
      .EXE_over     (EXE_over),
      .EXE_MEM_bus  (EXE_MEM_bus),
      .EXE_wdest    (EXE_wdest),
      .EXE_pc       (EXE_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // op: 0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,11 lui, else none
   function automatic instr_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic mul);
      instr_t i;
      i.op    = op;
      i.mul   = mul;
      i.mthi  = 1'b0;
      i.mtlo  = 1'b0;
      i.ctl   = (op >= 0 && op < 12) ? (12'h800 >> op) : 12'h000;
      i.a     = a;
      i.b     = b;
      i.memc  = 4'($urandom);
      i.sd    = $urandom;
      i.flags = 4'($urandom);
      i.cp0   = 8'($urandom);
      i.se    = 2'($urandom);
      i.wen   = 1'($urandom);
      i.wd    = 5'($urandom_range(1, 31));
      i.pc    = $urandom & 32'hFFFF_FFFC;
      return i;
   endfunction

   function automatic logic [166:0] id_bus(input instr_t i);
      return {i.mul, i.mthi, i.mtlo, i.ctl, i.a, i.b, i.memc, i.sd, i.flags, i.cp0,
              i.se, i.wen, i.wd, i.pc};
   endfunction

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return (sa < sb) ? 32'd1 : 32'd0;
         3:  return (a < b) ? 32'd1 : 32'd0;
         4:  return a & b;
         5:  return ~(a | b);
         6:  return a | b;
         7:  return a ^ b;
         8:  return b << a[4:0];
         9:  return b >> a[4:0];
         10: return 32'(sb >>> a[4:0]);
         11: return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [153:0] exp_mem(input instr_t i);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      logic [31:0] exe;
      logic [31:0] lo;
      sa = longint'($signed(i.a));
      sb = longint'($signed(i.b));
      p  = sa * sb;
      if (i.mul) begin
         exe = p[63:32];
         lo  = p[31:0];
      end else begin
         exe = (i.mthi | i.mtlo) ? i.a : ref_alu(i.op, i.a, i.b);
         lo  = i.a;
      end
      return {i.memc, i.sd, exe, lo, i.mul | i.mthi, i.mul | i.mtlo, i.flags, i.cp0,
              i.se, i.wen, i.wd, i.pc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input instr_t i);
      ID_EXE_bus   = id_bus(i);
      ID_over      = 1'b1;
      MEM_allow_in = 1'b1;
      #1;
      total++;
      if (EXE_allow_in !== 1'b1) begin
         bad++;
         $display("FAIL issue_allow: got %b want 1", EXE_allow_in);
      end
      step();
      ID_over = 1'b0;
   endtask

   task automatic wait_over(output int cyc);
      cyc = 0;
      while (EXE_over !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
   endtask

   task automatic drive_alu(input instr_t i, input string nm, input int stall,
                            output logic [31:0] res);
      logic [153:0] exp;
      exp = exp_mem(i);
      issue(i);
      res = EXE_MEM_bus[117:86];
      total++;
      if (EXE_over !== 1'b1) begin
         bad++;
         $display("FAIL %s over: got %b want 1", nm, EXE_over);
      end
      total++;
      if (EXE_MEM_bus !== exp) begin
         bad++;
         $display("FAIL %s bus: got %h want %h", nm, EXE_MEM_bus, exp);
      end
      total++;
      if (EXE_wdest !== i.wd || EXE_pc !== i.pc) begin
         bad++;
         $display("FAIL %s wdest/pc: got %0d/%h want %0d/%h", nm, EXE_wdest, EXE_pc, i.wd, i.pc);
      end
      MEM_allow_in = 1'b0;
      for (int k = 0; k < stall; k++) begin
         #1;
         total++;
         if (EXE_allow_in !== 1'b0 || EXE_over !== 1'b1 || EXE_MEM_bus !== exp) begin
            bad++;
            $display("FAIL %s stall: allow=%b over=%b bus=%h want allow=0 over=1 bus=%h",
                     nm, EXE_allow_in, EXE_over, EXE_MEM_bus, exp);
         end
         step();
      end
      MEM_allow_in = 1'b1;
      step();
      total++;
      if (EXE_valid !== 1'b0 || EXE_wdest !== 5'd0) begin
         bad++;
         $display("FAIL %s drain: valid=%b wdest=%0d want 0/0", nm, EXE_valid, EXE_wdest);
      end
   endtask

   task automatic run_mult(input instr_t i, input string nm, output logic [31:0] hi,
                           output logic [31:0] lo);
      logic [153:0] exp;
      int           cyc;
      exp = exp_mem(i);
      issue(i);
      total++;
      if (EXE_over !== 1'b0 || EXE_allow_in !== 1'b0) begin
         bad++;
         $display("FAIL %s busy: over=%b allow=%b want 0/0", nm, EXE_over, EXE_allow_in);
      end
      wait_over(cyc);
      total++;
      if (cyc != MUL_LAT) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", nm, cyc, MUL_LAT);
      end
      hi = EXE_MEM_bus[117:86];
      lo = EXE_MEM_bus[85:54];
      total++;
      if (EXE_MEM_bus !== exp) begin
         bad++;
         $display("FAIL %s bus: got %h want %h", nm, EXE_MEM_bus, exp);
      end
      step();
      total++;
      if (EXE_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s drain: valid=%b want 0", nm, EXE_valid);
      end
   endtask

   task automatic check_reset_outputs(input string nm);
      total++;
      if (EXE_valid !== 1'b0 || EXE_over !== 1'b0 || EXE_allow_in !== 1'b1 ||
          EXE_wdest !== 5'd0 || EXE_MEM_bus !== 154'd0 || EXE_pc !== 32'd0) begin
         bad++;
         $display("FAIL %s: valid=%b over=%b allow=%b wdest=%0d pc=%h bus=%h want 0 0 1 0 0 0",
                  nm, EXE_valid, EXE_over, EXE_allow_in, EXE_wdest, EXE_pc, EXE_MEM_bus);
      end
   endtask

   task automatic test_reset();
      resetn       = 1'b0;
      ID_over      = 1'b0;
      ID_EXE_bus   = '0;
      MEM_allow_in = 1'b1;
      cancel       = 1'b0;
      repeat (2) step();
      check_reset_outputs("reset");
      resetn = 1'b1;
      step();
      check_reset_outputs("reset_release");
   endtask

   task automatic test_alu_directed();
      logic [31:0] r;
      drive_alu(mk(0, 32'h7FFF_FFFF, 32'h1, 1'b0), "add_wrap", 0, r);
      total++;
      if (r !== 32'h8000_0000) begin
         bad++;
         $display("FAIL add_wrap result: got %h want 80000000", r);
      end
      drive_alu(mk(2, 32'hFFFF_FFFF, 32'h1, 1'b0), "slt", 0, r);
      total++;
      if (r !== 32'd1) begin
         bad++;
         $display("FAIL slt result: got %h want 1", r);
      end
      drive_alu(mk(3, 32'hFFFF_FFFF, 32'h1, 1'b0), "sltu", 0, r);
      total++;
      if (r !== 32'd0) begin
         bad++;
         $display("FAIL sltu result: got %h want 0", r);
      end
      drive_alu(mk(10, 32'd4, 32'hF000_0000, 1'b0), "sra", 0, r);
      total++;
      if (r !== 32'hFF00_0000) begin
         bad++;
         $display("FAIL sra result: got %h want ff000000", r);
      end
      drive_alu(mk(12, $urandom, $urandom, 1'b0), "no_op", 0, r);
      total++;
      if (r !== 32'd0) begin
         bad++;
         $display("FAIL no_op result: got %h want 0", r);
      end
   endtask

   task automatic test_alu_random();
      instr_t      i;
      logic [31:0] r;
      for (int n = 0; n < 40; n++) begin
         i = mk($urandom_range(0, 12), $urandom, $urandom, 1'b0);
         if ($urandom_range(0, 3) == 0) i.a = i.a & 32'h1F;
         i.mthi = ($urandom_range(0, 7) == 0);
         i.mtlo = ($urandom_range(0, 7) == 0);
         drive_alu(i, $sformatf("alu_rand%0d", n), $urandom_range(0, 2), r);
      end
   endtask

   task automatic test_mult();
      logic [31:0] hi;
      logic [31:0] lo;
      run_mult(mk(0, 32'hFFFF_FFFD, 32'd5, 1'b1), "mult_m3x5", hi, lo);
      total++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1 || EXE_MEM_bus[53:52] !== 2'b11) begin
         bad++;
         $display("FAIL mult_m3x5 fields: hi=%h lo=%h hw/lw=%b want ffffffff fffffff1 11",
                  hi, lo, EXE_MEM_bus[53:52]);
      end
      run_mult(mk(0, 32'd0, 32'h8000_0001, 1'b1), "mult_zero_a", hi, lo);
      run_mult(mk(0, 32'hFFFF_FFF0, 32'd0, 1'b1), "mult_zero_b", hi, lo);
      total++;
      if (hi !== 32'd0 || lo !== 32'd0) begin
         bad++;
         $display("FAIL mult_zero_b value: hi=%h lo=%h want 0 0", hi, lo);
      end
      run_mult(mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1), "mult_m1xm1", hi, lo);
      run_mult(mk(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1), "mult_maxmin", hi, lo);
      for (int n = 0; n < 4; n++) begin
         run_mult(mk($urandom_range(0, 11), $urandom, $urandom, 1'b1),
                  $sformatf("mult_rand%0d", n), hi, lo);
      end
   endtask

   task automatic test_backpressure();
      instr_t       m;
      instr_t       nxt;
      logic [153:0] exp;
      int           cyc;
      m   = mk(0, $urandom, $urandom, 1'b1);
      exp = exp_mem(m);
      issue(m);
      MEM_allow_in = 1'b0;
      wait_over(cyc);
      total++;
      if (cyc != MUL_LAT) begin
         bad++;
         $display("FAIL bp latency: got %0d want %0d", cyc, MUL_LAT);
      end
      nxt        = mk($urandom_range(0, 11), $urandom, $urandom, 1'b0);
      ID_EXE_bus = id_bus(nxt);
      ID_over    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (EXE_allow_in !== 1'b0 || EXE_over !== 1'b1 || EXE_MEM_bus !== exp) begin
            bad++;
            $display("FAIL bp hold%0d: allow=%b over=%b bus=%h want 0 1 %h",
                     k, EXE_allow_in, EXE_over, EXE_MEM_bus, exp);
         end
         step();
      end
      MEM_allow_in = 1'b1;
      #1;
      total++;
      if (EXE_allow_in !== 1'b1) begin
         bad++;
         $display("FAIL bp release allow: got %b want 1", EXE_allow_in);
      end
      step();
      ID_over = 1'b0;
      total++;
      if (EXE_MEM_bus !== exp_mem(nxt) || EXE_over !== 1'b1 || EXE_wdest !== nxt.wd) begin
         bad++;
         $display("FAIL bp next: bus=%h over=%b wdest=%0d want %h 1 %0d",
                  EXE_MEM_bus, EXE_over, EXE_wdest, exp_mem(nxt), nxt.wd);
      end
      step();
      total++;
      if (EXE_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp drain: valid=%b want 0", EXE_valid);
      end
   endtask

   task automatic test_cancel();
      instr_t      n;
      logic [31:0] hi;
      logic [31:0] lo;
      issue(mk(0, $urandom, $urandom, 1'b1));
      repeat (10) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      total++;
      if (EXE_valid !== 1'b0 || EXE_wdest !== 5'd0 || EXE_over !== 1'b0 ||
          EXE_allow_in !== 1'b1) begin
         bad++;
         $display("FAIL cancel_busy: valid=%b wdest=%0d over=%b allow=%b want 0 0 0 1",
                  EXE_valid, EXE_wdest, EXE_over, EXE_allow_in);
      end
      n          = mk(0, $urandom, $urandom, 1'b0);
      ID_EXE_bus = id_bus(n);
      ID_over    = 1'b1;
      cancel     = 1'b1;
      step();
      ID_over = 1'b0;
      cancel  = 1'b0;
      total++;
      if (EXE_valid !== 1'b0 || EXE_wdest !== 5'd0) begin
         bad++;
         $display("FAIL cancel_vs_latch: valid=%b wdest=%0d want 0 0", EXE_valid, EXE_wdest);
      end
      run_mult(mk(0, 32'h8000_0000, 32'h8000_0000, 1'b1), "mult_minxmin", hi, lo);
      total++;
      if (hi !== 32'h4000_0000 || lo !== 32'd0) begin
         bad++;
         $display("FAIL mult_minxmin value: hi=%h lo=%h want 40000000 0", hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      instr_t m1;
      instr_t m2;
      int     cyc;
      m1 = mk(0, $urandom, $urandom, 1'b1);
      m2 = mk(0, $urandom, $urandom, 1'b1);
      issue(m1);
      wait_over(cyc);
      total++;
      if (cyc != MUL_LAT || EXE_MEM_bus !== exp_mem(m1)) begin
         bad++;
         $display("FAIL b2b first: cyc=%0d bus=%h want %0d %h", cyc, EXE_MEM_bus, MUL_LAT,
                  exp_mem(m1));
      end
      ID_EXE_bus = id_bus(m2);
      ID_over    = 1'b1;
      step();
      ID_over = 1'b0;
      wait_over(cyc);
      total++;
      if (cyc != MUL_LAT || EXE_MEM_bus !== exp_mem(m2)) begin
         bad++;
         $display("FAIL b2b second: cyc=%0d bus=%h want %0d %h", cyc, EXE_MEM_bus, MUL_LAT,
                  exp_mem(m2));
      end
      step();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [31:0] hi;
      logic [31:0] lo;
      issue(mk(0, $urandom, $urandom, 1'b1));
      repeat (15) step();
      resetn = 1'b0;
      #1;
      check_reset_outputs("reset_mid");
      step();
      check_reset_outputs("reset_mid_hold");
      resetn = 1'b1;
      drive_alu(mk(0, $urandom, $urandom, 1'b0), "addu_after_reset", 0, r);
      run_mult(mk(0, $urandom, $urandom, 1'b1), "mult_after_reset", hi, lo);
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_alu_random();
      test_mult();
      test_backpressure();
      test_cancel();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
